ram8: RTL and testbench



---
 rtl/ram8_pkg.sv | 6 +
 rtl/ram8_word_register.sv | 17 +
 rtl/ram8.sv | 29 ++
 tb/tb_ram8.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ram8_pkg.sv
// ram8_pkg: constants shared by ram8 and the larger RAM stages built on it
package ram8_pkg;
  localparam int RAM8_DEPTH = 8;
  localparam int RAM8_ADDR_W = 3;
  localparam int WORD_WIDTH = 16;
endpackage

// File: rtl/ram8_word_register.sv
// word_register: WIDTH one-bit load-enabled storage cells with async active-low clear
module word_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    // one bit cell: clear on reset, capture on load, otherwise hold
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) out[b] <= 1'b0;
      else if (load) out[b] <= in[b];
  end
endmodule

// File: rtl/ram8.sv
// ram8: eight-word memory with combinational read and synchronous single-word write
module ram8
  import ram8_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]       out
);
  logic [WIDTH-1:0] words [RAM8_DEPTH];
  logic [RAM8_DEPTH-1:0] loads;
  // one-hot decode so at most one word captures per edge
  always_comb
    for (int i = 0; i < RAM8_DEPTH; i++) loads[i] = load && (address == RAM8_ADDR_W'(i));
  for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
    word_register #(.WIDTH(WIDTH)) u_word (
      .clk(clk),
      .rst_n(rst_n),
      .in(in),
      .load(loads[i]),
      .out(words[i])
    );
  end
  assign out = words[address];
endmodule

// File: tb/tb_ram8.sv
// tb_ram8: random and directed checks of ram8 against an array model
module tb_ram8;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] in;
  logic load;
  logic [2:0] address;
  logic [15:0] out;
  logic in1, load1, out1;
  logic [2:0] addr1;
  int checks = 0;
  int failures = 0;
  logic [15:0] m [8] = '{default: 16'h0};
  logic m1 [8] = '{default: 1'b0};

  ram8 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .in(in), .load(load), .address(address), .out(out));
  ram8 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .in(in1), .load(load1), .address(addr1), .out(out1));

  always #5 clk = ~clk;

  // reference memory: cleared asynchronously, written at the edge when enabled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m[i] = 16'h0;
        m1[i] = 1'b0;
      end
    end else begin
      if (load) m[address] = in;
      if (load1) m1[addr1] = in1;
    end
  end

  // every cycle, the selected word must match the model (zero while in reset)
  always @(negedge clk) begin
    logic [15:0] e;
    logic e1;
    e = rst_n ? m[address] : 16'h0;
    e1 = rst_n ? m1[addr1] : 1'b0;
    checks++;
    if (out !== e) begin
      failures++;
      $display("FAIL model16 t=%0t addr=%0d got=%h exp=%h", $time, address, out, e);
    end
    checks++;
    if (out1 !== e1) begin
      failures++;
      $display("FAIL model1 t=%0t addr=%0d got=%b exp=%b", $time, addr1, out1, e1);
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in = d;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    in = 16'h0;
    load = 1'b0;
    address = 3'd0;
    in1 = 1'b0;
    load1 = 1'b0;
    addr1 = 3'd0;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1 chk("reset_sweep", out, 16'h0000);
    end
    address = 3'd2;
    in = 16'hFFFF;
    load = 1'b1;
    step();
    step();
    load = 1'b0;
    rst_n = 1'b1;
    #1 chk("load_in_reset_discarded", out, 16'h0000);
    step();
    for (int i = 0; i < 8; i++) write(3'(i), 16'(16'h1111 * i));
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1 chk("readback", out, 16'(16'h1111 * i));
    end
    write(3'd3, 16'hBEEF);
    in = 16'h1234;
    address = 3'd3;
    repeat (3) step();
    chk("hold", out, 16'hBEEF);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1 chk("hold_others", out, i == 3 ? 16'hBEEF : 16'(16'h1111 * i));
    end
    write(3'd5, 16'h00FF);
    address = 3'd5;
    in = 16'hFF00;
    load = 1'b1;
    #1 chk("rdw_before", out, 16'h00FF);
    step();
    load = 1'b0;
    chk("rdw_after", out, 16'hFF00);
    address = 3'd4;
    #1 chk("rdw_word4", out, 16'h4444);
    address = 3'd6;
    #1 chk("rdw_word6", out, 16'h6666);
    write(3'd0, 16'h0F0F);
    address = 3'd6;
    #1 rst_n = 1'b0;
    #1 chk("async_reset", out, 16'h0000);
    step();
    rst_n = 1'b1;
    write(3'd7, 16'hA5A5);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1 chk("after_reset_only7", out, i == 7 ? 16'hA5A5 : 16'h0000);
    end
    addr1 = 3'd3;
    in1 = 1'b1;
    load1 = 1'b1;
    step();
    addr1 = 3'd2;
    step();
    addr1 = 3'd3;
    in1 = 1'b0;
    step();
    load1 = 1'b0;
    addr1 = 3'd2;
    #1 chk("w1_word2", {15'h0, out1}, 16'h0001);
    addr1 = 3'd3;
    #1 chk("w1_word3", {15'h0, out1}, 16'h0000);
    for (int n = 0; n < 500; n++) begin
      address = 3'($urandom);
      in = 16'($urandom);
      load = 1'($urandom);
      addr1 = 3'($urandom);
      in1 = 1'($urandom);
      load1 = 1'($urandom);
      rst_n = ($urandom_range(0, 39) != 0);
      step();
    end
    rst_n = 1'b1;
    load = 1'b0;
    load1 = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
